dm_rmw_ctrl: RTL and testbench
==============================

# dm_rmw_ctrl

Data-memory access controller between the MEM stage and a word-only data memory (no byte enables). It accepts one load or store request at a time and performs word stores directly. Halfword and byte stores are done as read-modify-write sequences: read the old word, merge the new lanes, write it back. Misaligned accesses are rejected with an error response and never touch memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  2  access type: 00 load, 01 word store, 10 halfword store, 11 byte store
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned (sh uses [15:0], sb uses [7:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  with resp_valid: request was misaligned
- resp_rdata  out  32  raw memory word for loads; 0 for stores and errors
- mem_addr  out  ADDR_W-2  word address (req_addr[ADDR_W-1:2])
- mem_re  out  1  memory read strobe; rdata valid the following cycle
- mem_we  out  1  full-word write strobe
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, 1-cycle synchronous latency

## Operation
- FSM states: IDLE, RD, WAIT, WR, RESP.
- Handshake:
  - A request is accepted when req_valid & req_ready.
  - All req_* inputs are registered on accept and ignored at every other time.
- Misaligned requests:
  - Word with addr[1:0]≠00 is misaligned; halfword with addr[0]=1 is misaligned.
  - Path: IDLE→RESP with resp_err=1.
- Load: IDLE→RD→WAIT→RESP.
  - RD asserts mem_re.
  - WAIT captures mem_rdata into resp_rdata.
- Word store: IDLE→WR→RESP. WR asserts mem_we with the registered wdata.
- Sub-word store: IDLE→RD→WAIT→WR→RESP.
  - Lane mask:
    - halfword: ad=00 → 0011, ad=10 → 1100
    - byte: ad=n → one-hot bit n
  - Lane data: halfword {2{wdata[15:0]}}, byte {4{wdata[7:0]}}.
  - In WAIT: merged = (lane & mask) | (mem_rdata & ~mask), registered.
  - WR writes the merged word.
- RESP: resp_valid=1 for one cycle, then IDLE.
- No response backpressure; the consumer must take the pulse.
- mem_addr holds the registered word address from RD through WR and is 0 in IDLE.

## Timing
- Latency from accept edge to the resp_valid cycle:
  - misaligned: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- req_ready is combinational from state; it is 0 in the RESP cycle, so a new accept happens no earlier than the cycle after RESP.
- Outputs are registered except req_ready, mem_re and mem_we, which are decoded from state. At most one of mem_re/mem_we is high in any cycle.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_wdata=0, mem_addr=0.
- Reset mid-operation:
  - The in-flight request is dropped, with no response.
  - mem_we and mem_re fall asynchronously with reset_n.
  - A partially completed RMW never writes.
- A req_valid high during reset is not accepted. The first accept can occur on the first rising edge after reset_n deasserts.

## Structure
- Shared package dm_pkg holds:
  - access-type constants WE_LOAD=2'b00, WE_WORD=2'b01, WE_HALF=2'b10, WE_BYTE=2'b11
  - FSM state encoding
  - lane-mask constants (0011, 1100, 0001…1000)
- One combinational sub-module, dm_lane_merge:
  - inputs: type, addr[1:0], wdata, old word
  - outputs: mask, merged word, misaligned flag
- The FSM and all registers stay in dm_rmw_ctrl.

## Test plan
- Word store addr 0x10, wdata 0xDEADBEEF → WR cycle with mem_addr=0x4, mem_wdata=0xDEADBEEF, mem_re never high; resp_valid 2 cycles after accept, resp_err=0.
- Memory word 0x11223344 at 0x20; byte store addr 0x22, wdata 0x000000AA → mem_re, then mem_we with 0x11AA3344; resp 4 cycles after accept.
- Same initial word; halfword store addr 0x22, wdata 0x0000BEEF → mem_wdata=0xBEEF3344. Then a load from 0x20 → resp_rdata=0xBEEF3344 at latency 3.
- Halfword store addr 0x21 and word store addr 0x22 → each gives resp_valid=1, resp_err=1 one cycle after accept; mem_re=mem_we=0 throughout.
- Hold req_valid high with back-to-back requests → req_ready low from accept through RESP; exactly one response per accept, in order.
- Assert reset_n=0 during WAIT of a byte store → mem_we never asserts, no resp_valid; all outputs return to reset values immediately.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory read-modify-write controller:
// access-type codes, FSM state encoding and byte-lane mask constants.
package dm_pkg;

    // Access type carried on req_we
    localparam logic [1:0] WE_LOAD = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_BYTE = 2'b11;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Byte-lane masks, bit n selects bits [8n+7:8n] of the word
    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_WORD    = 4'b1111;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;
    localparam logic [3:0] MASK_BYTE1   = 4'b0010;
    localparam logic [3:0] MASK_BYTE2   = 4'b0100;
    localparam logic [3:0] MASK_BYTE3   = 4'b1000;

    // Widen a 4-bit lane mask to a 32-bit bit mask
    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Combinational lane logic: decodes the access type and low address bits
// into a byte-lane mask, flags misaligned accesses and merges the
// replicated store data into an old memory word.
module dm_lane_merge
    import dm_pkg::*;
(
    input  logic [1:0]  we_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_i,
    output logic [3:0]  mask_o,
    output logic [31:0] merged_o,
    output logic        misaligned_o
);

    logic [31:0] lane;
    logic [31:0] bit_mask;

    // Decode lane mask, replicated lane data and alignment
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        mask_o       = MASK_NONE;
        lane         = '0;
        misaligned_o = 1'b0;
        case (we_i)
            WE_WORD: begin
                mask_o       = MASK_WORD;
                lane         = wdata_i;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            WE_HALF: begin
                mask_o       = addr_lo_i[1] ? MASK_HALF_HI : MASK_HALF_LO;
                lane         = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            WE_BYTE: begin
                lane = {4{wdata_i[7:0]}};
                case (addr_lo_i)
                    2'b00:   mask_o = MASK_BYTE0;
                    2'b01:   mask_o = MASK_BYTE1;
                    2'b10:   mask_o = MASK_BYTE2;
                    default: mask_o = MASK_BYTE3;
                endcase
            end
            default: ; // loads touch no lanes
        endcase
    end

    assign bit_mask = expand_mask(mask_o);
    assign merged_o = (lane & bit_mask) | (old_i & ~bit_mask);

endmodule

// File: rtl/dm_rmw_ctrl.sv
// Data-memory access controller for a word-only memory. Loads and word
// stores go straight to memory; halfword and byte stores read the old word,
// merge the new lanes and write it back. Misaligned requests are answered
// with an error and never reach memory.
module dm_rmw_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic [1:0]        we_q, we_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic              in_idle;
    logic              accept;
    logic [1:0]        sel_we;
    logic [1:0]        sel_addr_lo;
    logic [31:0]       sel_wdata;
    logic [3:0]        lane_mask;
    logic [31:0]       merged;
    logic              misaligned;

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = req_valid & in_idle;

    // In IDLE the live request is decoded (alignment, word-store data);
    // afterwards only the registered copy is used.
    assign sel_we      = in_idle ? req_we         : we_q;
    assign sel_addr_lo = in_idle ? req_addr[1:0]  : addr_lo_q;
    assign sel_wdata   = in_idle ? req_wdata      : wdata_q;

    dm_lane_merge u_lane_merge (
        .we_i         (sel_we),
        .addr_lo_i    (sel_addr_lo),
        .wdata_i      (sel_wdata),
        .old_i        (mem_rdata),
        .mask_o       (lane_mask),
        .merged_o     (merged),
        .misaligned_o (misaligned)
    );

    // Next-state and register-update decode; strobes are pure state decodes
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = '0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d      = req_we;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata;
                    if (misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (lane_mask == MASK_WORD) begin
                        // Full-word store needs no read of the old word
                        state_d     = ST_WR;
                        mem_addr_d  = req_addr[ADDR_W-1:2];
                        mem_wdata_d = merged;
                    end else begin
                        state_d    = ST_RD;
                        mem_addr_d = req_addr[ADDR_W-1:2];
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (we_q == WE_LOAD) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_rdata;
                    mem_addr_d   = '0;
                end else begin
                    state_d     = ST_WR;
                    mem_wdata_d = merged;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                mem_addr_d   = '0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                mem_addr_d = '0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            we_q         <= WE_LOAD;
            addr_lo_q    <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            we_q         <= we_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = in_idle;
    assign mem_re     = (state_q == ST_RD);
    assign mem_we     = (state_q == ST_WR);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// Directed bench for dm_rmw_ctrl with a small synchronous word memory.
module tb_dm_rmw_ctrl;
    import dm_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    dm_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Word memory, one-cycle read latency
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[3:0]];
        if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    end

    // Activity monitor sampled on the falling edge
    int          re_cnt = 0, we_cnt = 0, both_cnt = 0, resp_cnt = 0;
    int          acc_cnt = 0, rdy_in_resp = 0;
    logic [29:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic        log_err [64];
    logic [31:0] log_rd  [64];
    always @(negedge clk) begin
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_we) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
        if (mem_re && mem_we) both_cnt <= both_cnt + 1;
        if (resp_valid) begin
            log_err[resp_cnt[5:0]] <= resp_err;
            log_rd[resp_cnt[5:0]]  <= resp_rdata;
            resp_cnt <= resp_cnt + 1;
            if (req_ready) rdy_in_resp <= rdy_in_resp + 1;
        end
        if (reset_n && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then wait (bounded) for its response pulse
    task automatic run_req(input logic [1:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic err, output logic [31:0] rdata,
                           output logic rdy_ok);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        lat    = 0;
        err    = 1'b0;
        rdata  = '0;
        rdy_ok = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (req_ready) rdy_ok = 1'b0;
            if (resp_valid) begin
                lat   = i;
                err   = resp_err;
                rdata = resp_rdata;
                break;
            end
        end
    endtask

    task automatic txn(input string tag, input logic [1:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_lat, input logic exp_err,
                       input logic [31:0] exp_rd, input int exp_re, input int exp_we,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_waddr);
        int          re0;
        int          we0;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        rdy_ok;
        re0 = re_cnt;
        we0 = we_cnt;
        run_req(we, addr, wdata, lat, err, rdata, rdy_ok);
        check({tag, "_lat"},   32'(lat),    32'(exp_lat));
        check({tag, "_err"},   32'(err),    32'(exp_err));
        check({tag, "_rdata"}, rdata,       exp_rd);
        check({tag, "_ready"}, 32'(rdy_ok), 32'd1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        #1;
        check({tag, "_nre"}, 32'(re_cnt - re0), 32'(exp_re));
        check({tag, "_nwe"}, 32'(we_cnt - we0), 32'(exp_we));
        if (exp_we > 0) begin
            check({tag, "_waddr"}, 32'(last_waddr), exp_waddr);
            check({tag, "_wdata"}, last_wdata,      exp_wdata);
        end
    endtask

    // Back-to-back stimulus table
    logic [1:0]  bw [3];
    logic [31:0] ba [3];
    logic [31:0] bd [3];
    int          r0, a0, w0;
    logic        got;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        bw[0] = WE_WORD; ba[0] = 32'h30; bd[0] = 32'h0BADF00D;
        bw[1] = WE_HALF; ba[1] = 32'h31; bd[1] = 32'h00001111;
        bw[2] = WE_LOAD; ba[2] = 32'h30; bd[2] = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready),  32'd1);
        check("rst_rv",    32'(resp_valid), 32'd0);
        check("rst_err",   32'(resp_err),   32'd0);
        check("rst_rdata", resp_rdata,      32'd0);
        check("rst_re",    32'(mem_re),     32'd0);
        check("rst_we",    32'(mem_we),     32'd0);
        check("rst_wdata", mem_wdata,       32'd0);
        check("rst_addr",  32'(mem_addr),   32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Word stores, sub-word stores, loads
        txn("sw10",  WE_WORD, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0,        0, 1, 32'hDEADBEEF, 32'h4);
        txn("sw20",  WE_WORD, 32'h20, 32'h11223344, 2, 1'b0, 32'h0,        0, 1, 32'h11223344, 32'h8);
        txn("sb22",  WE_BYTE, 32'h22, 32'h000000AA, 4, 1'b0, 32'h0,        1, 1, 32'h11AA3344, 32'h8);
        txn("sw20b", WE_WORD, 32'h20, 32'h11223344, 2, 1'b0, 32'h0,        0, 1, 32'h11223344, 32'h8);
        txn("sh22",  WE_HALF, 32'h22, 32'h0000BEEF, 4, 1'b0, 32'h0,        1, 1, 32'hBEEF3344, 32'h8);
        txn("ld20",  WE_LOAD, 32'h20, 32'h0,        3, 1'b0, 32'hBEEF3344, 1, 0, 32'h0,        32'h0);
        txn("ld10",  WE_LOAD, 32'h10, 32'hFFFFFFFF, 3, 1'b0, 32'hDEADBEEF, 1, 0, 32'h0,        32'h0);
        txn("sb23",  WE_BYTE, 32'h23, 32'hFFFFFF77, 4, 1'b0, 32'h0,        1, 1, 32'h77EF3344, 32'h8);
        txn("sh20",  WE_HALF, 32'h20, 32'hAAAA1234, 4, 1'b0, 32'h0,        1, 1, 32'h77EF1234, 32'h8);
        txn("ld20b", WE_LOAD, 32'h20, 32'h0,        3, 1'b0, 32'h77EF1234, 1, 0, 32'h0,        32'h0);

        // Misaligned requests
        txn("mis_sh21", WE_HALF, 32'h21, 32'h00001234, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
        txn("mis_sw22", WE_WORD, 32'h22, 32'hDEADBEEF, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);
        txn("mis_sh23", WE_HALF, 32'h23, 32'h0000FFFF, 1, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0);

        // Back-to-back with req_valid held high
        @(posedge clk); #1;
        r0 = resp_cnt;
        a0 = acc_cnt;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_we    = bw[k];
            req_addr  = ba[k];
            req_wdata = bd[k];
            got       = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (req_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            check($sformatf("b2b_acc%0d", k), 32'(got), 32'd1);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (resp_cnt - r0 >= 3) break;
            @(negedge clk); #1;
        end
        check("b2b_nresp", 32'(resp_cnt - r0), 32'd3);
        check("b2b_nacc",  32'(acc_cnt - a0),  32'd3);
        check("b2b_err0",  32'(log_err[r0[5:0]]),       32'd0);
        check("b2b_err1",  32'(log_err[6'(r0 + 1)]),    32'd1);
        check("b2b_err2",  32'(log_err[6'(r0 + 2)]),    32'd0);
        check("b2b_rd1",   log_rd[6'(r0 + 1)],          32'h0);
        check("b2b_rd2",   log_rd[6'(r0 + 2)],          32'h0BADF00D);

        // Reset in the WAIT cycle of a byte store
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = WE_BYTE;
        req_addr  = 32'h20;
        req_wdata = 32'h00000099;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rd_re", 32'(mem_re), 32'd1);
        @(negedge clk);
        check("rmw_wait_re", 32'(mem_re), 32'd0);
        #1;
        w0 = we_cnt;
        r0 = resp_cnt;
        reset_n = 1'b0;
        #1;
        check("arst_we",    32'(mem_we),     32'd0);
        check("arst_re",    32'(mem_re),     32'd0);
        check("arst_ready", 32'(req_ready),  32'd1);
        check("arst_rv",    32'(resp_valid), 32'd0);
        check("arst_err",   32'(resp_err),   32'd0);
        check("arst_rdata", resp_rdata,      32'd0);
        check("arst_addr",  32'(mem_addr),   32'd0);
        check("arst_wdata", mem_wdata,       32'd0);
        req_valid = 1'b1;
        req_we    = WE_WORD;
        req_addr  = 32'h10;
        req_wdata = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        check("arst_nwe",   32'(we_cnt - w0),   32'd0);
        check("arst_nresp", 32'(resp_cnt - r0), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFFFFFF;
        req_wdata = 32'h0;
        @(negedge clk);
        check("first_we",    32'(mem_we),   32'd1);
        check("first_addr",  32'(mem_addr), 32'h4);
        check("first_wdata", mem_wdata,     32'hCAFEF00D);
        @(negedge clk);
        check("first_rv",  32'(resp_valid), 32'd1);
        check("first_err", 32'(resp_err),   32'd0);
        txn("ld20_post", WE_LOAD, 32'h20, 32'h0, 3, 1'b0, 32'h77EF1234, 1, 0, 32'h0, 32'h0);
        txn("ld10_post", WE_LOAD, 32'h10, 32'h0, 3, 1'b0, 32'hCAFEF00D, 1, 0, 32'h0, 32'h0);

        // Global properties
        check("strobe_excl",   32'(both_cnt),    32'd0);
        check("ready_in_resp", 32'(rdy_in_resp), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
